// File: rtl/zverif_trace_buffer.sv
// zverif_trace_buffer: elastic buffer between the core's instruction-trace
// port and a host-facing valid/ready stream. The core is never stalled:
// words arriving with no room are dropped and counted.
//
// Optional feature macro: ZVERIF_TRACE_MARKER_EN
//   defined   -> after a burst of drops, one marker word
//                {4'hF, 16'h0000, dropped_count} is written into the FIFO.
//   undefined -> drops are silent; only overflow/drop_total report them.
module zverif_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          trace_valid,
    input  logic [35:0]   trace_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [35:0]   out_data,
    output logic [AW:0]   level,
    output logic          overflow,
    output logic [31:0]   drop_total
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

`ifdef ZVERIF_TRACE_MARKER_EN
    typedef enum logic {
        ST_NORMAL,
        ST_DROP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ep_count_q, ep_count_d;
    logic [15:0] ep_marker;
`endif

    logic [35:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic [31:0] drop_total_q, drop_total_d;
    logic [31:0] drop_total_inc;

    logic        empty;
    logic        full;
    logic        pop;
    logic        space;
    logic        wr_en;
    logic [35:0] wr_data;

    // Occupancy flags from the extra pointer wrap bit; a pop in the same
    // cycle frees one slot for an incoming word.
    always_comb begin
        empty          = (wr_ptr_q == rd_ptr_q);
        full           = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop            = !empty && out_ready;
        space          = !full || pop;
        drop_total_inc = (drop_total_q == 32'hFFFF_FFFF) ? drop_total_q
                                                         : drop_total_q + 32'd1;
`ifdef ZVERIF_TRACE_MARKER_EN
        ep_marker      = (trace_valid && ep_count_q != 16'hFFFF) ? ep_count_q + 16'd1
                                                                 : ep_count_q;
`endif
    end

    // Next-state: pointers, drop accounting and (optionally) the marker FSM.
    always_comb begin
        wr_en        = 1'b0;
        wr_data      = trace_data;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = overflow_q;
        drop_total_d = drop_total_q;
`ifdef ZVERIF_TRACE_MARKER_EN
        state_d      = state_q;
        ep_count_d   = ep_count_q;
`endif
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
`ifdef ZVERIF_TRACE_MARKER_EN
            state_d    = ST_NORMAL;
            ep_count_d = 16'd0;
`endif
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
`ifdef ZVERIF_TRACE_MARKER_EN
            case (state_q)
                ST_NORMAL: begin
                    if (trace_valid) begin
                        if (space) begin
                            wr_en = 1'b1;
                        end else begin
                            ep_count_d   = 16'd1;
                            overflow_d   = 1'b1;
                            drop_total_d = drop_total_inc;
                            state_d      = ST_DROP;
                        end
                    end
                end
                ST_DROP: begin
                    if (space) begin
                        wr_en      = 1'b1;
                        wr_data    = {4'hF, 16'h0000, ep_marker};
                        ep_count_d = 16'd0;
                        state_d    = ST_NORMAL;
                        if (trace_valid) begin
                            drop_total_d = drop_total_inc;
                        end
                    end else if (trace_valid) begin
                        ep_count_d   = ep_marker;
                        drop_total_d = drop_total_inc;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                end
            endcase
`else
            if (trace_valid) begin
                if (space) begin
                    wr_en = 1'b1;
                end else begin
                    overflow_d   = 1'b1;
                    drop_total_d = drop_total_inc;
                end
            end
`endif
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
        end
    end

    // Storage array; contents need no reset because pointers gate visibility.
    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            drop_total_q <= 32'd0;
`ifdef ZVERIF_TRACE_MARKER_EN
            state_q      <= ST_NORMAL;
            ep_count_q   <= 16'd0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            drop_total_q <= drop_total_d;
`ifdef ZVERIF_TRACE_MARKER_EN
            state_q      <= state_d;
            ep_count_q   <= ep_count_d;
`endif
        end
    end

    // Outputs come only from registered state; data reads as zero when empty.
    always_comb begin
        out_valid  = !empty;
        out_data   = empty ? 36'd0 : mem_q[rd_ptr_q[AW-1:0]];
        level      = wr_ptr_q - rd_ptr_q;
        overflow   = overflow_q;
        drop_total = drop_total_q;
    end

endmodule

// File: tb/tb_zverif_trace_buffer.sv
// Self-checking bench for zverif_trace_buffer (DEPTH = 16). Expectations
// adapt to whether ZVERIF_TRACE_MARKER_EN is defined for the build.
module tb_zverif_trace_buffer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          trace_valid;
    logic [35:0]   trace_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [35:0]   out_data;
    logic [AW:0]   level;
    logic          overflow;
    logic [31:0]   drop_total;

    int checks = 0;
    int passes = 0;
    int exp_dt = 0;
    logic [35:0] q [$];

    typedef struct packed {
        logic        tv;
        logic [35:0] d;
        logic        fl;
        logic        rdy;
        logic        e_ov;
        logic [35:0] e_od;
        logic [4:0]  e_lvl;
    } vec_t;

    vec_t vecs [10];

    zverif_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .trace_valid (trace_valid),
        .trace_data  (trace_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .level       (level),
        .overflow    (overflow),
        .drop_total  (drop_total)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle of inputs and advance to just after the clock edge
    task automatic applyStimulus(input logic tv, input logic [35:0] d, input logic fl, input logic rdy);
        trace_valid = tv;
        trace_data  = d;
        flush       = fl;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    // Push n words base..base+n-1 with the consumer stalled, tracking the model
    task automatic fillWords(input int n, input logic [35:0] base);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, base + 36'(i), 1'b0, 1'b0);
            q.push_back(base + 36'(i));
        end
    endtask

    // Pop everything the model holds, checking order, then confirm empty
    task automatic drainQueue(input string name);
        int budget;
        budget = 0;
        while (q.size() > 0 && budget < 64) begin
            checkOutput({name, "_valid"}, 36'(out_valid), 36'd1);
            checkOutput({name, "_data"}, out_data, q.pop_front());
            applyStimulus(1'b0, 36'd0, 1'b0, 1'b1);
            budget++;
        end
        checkOutput({name, "_budget"}, 36'(q.size()), 36'd0);
        out_ready = 1'b0;
        checkOutput({name, "_empty"}, 36'(out_valid), 36'd0);
        checkOutput({name, "_level0"}, 36'(level), 36'd0);
    endtask

    initial begin
        // Basic push/pop, latency, stall stability and flush vectors
        vecs[0] = '{1'b1, 36'h1_0000_0040, 1'b0, 1'b0, 1'b1, 36'h1_0000_0040, 5'd1};
        vecs[1] = '{1'b0, 36'h0,           1'b0, 1'b1, 1'b0, 36'h0,           5'd0};
        vecs[2] = '{1'b1, 36'h2_1234_5678, 1'b0, 1'b1, 1'b1, 36'h2_1234_5678, 5'd1};
        vecs[3] = '{1'b1, 36'h3_DEAD_BEEF, 1'b0, 1'b0, 1'b1, 36'h2_1234_5678, 5'd2};
        vecs[4] = '{1'b0, 36'h0,           1'b0, 1'b0, 1'b1, 36'h2_1234_5678, 5'd2};
        vecs[5] = '{1'b1, 36'h0_0000_0001, 1'b0, 1'b1, 1'b1, 36'h3_DEAD_BEEF, 5'd2};
        vecs[6] = '{1'b0, 36'h0,           1'b0, 1'b1, 1'b1, 36'h0_0000_0001, 5'd1};
        vecs[7] = '{1'b0, 36'h0,           1'b0, 1'b1, 1'b0, 36'h0,           5'd0};
        vecs[8] = '{1'b1, 36'h5_5555_5555, 1'b1, 1'b1, 1'b0, 36'h0,           5'd0};
        vecs[9] = '{1'b0, 36'h0,           1'b0, 1'b0, 1'b0, 36'h0,           5'd0};

        resetn = 1'b0;
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);
        checkOutput("rst_valid", 36'(out_valid), 36'd0);
        checkOutput("rst_data", out_data, 36'd0);
        checkOutput("rst_level", 36'(level), 36'd0);
        checkOutput("rst_overflow", 36'(overflow), 36'd0);
        checkOutput("rst_drop_total", 36'(drop_total), 36'd0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].tv, vecs[i].d, vecs[i].fl, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_valid", i), 36'(out_valid), 36'(vecs[i].e_ov));
            checkOutput($sformatf("vec%0d_data", i), out_data, vecs[i].e_od);
            checkOutput($sformatf("vec%0d_level", i), 36'(level), 36'(vecs[i].e_lvl));
            checkOutput($sformatf("vec%0d_overflow", i), 36'(overflow), 36'd0);
        end

        // Fill to capacity, overflow by three, then drain
        fillWords(16, 36'd0);
        checkOutput("full_level", 36'(level), 36'd16);
        checkOutput("full_overflow", 36'(overflow), 36'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 36'h0_0000_0100 + 36'(i), 1'b0, 1'b0);
        exp_dt = 3;
        checkOutput("ovf_level", 36'(level), 36'd16);
        checkOutput("ovf_overflow", 36'(overflow), 36'd1);
        checkOutput("ovf_drop_total", 36'(drop_total), 36'(exp_dt));
`ifdef ZVERIF_TRACE_MARKER_EN
        q.push_back(36'hF_0000_0003);
`endif
        drainQueue("drain_ovf");

        // Sustained push and pop on a full FIFO
        fillWords(16, 36'h0_0000_1000);
        for (int i = 0; i < 20; i++) begin
            checkOutput($sformatf("stream%0d_level", i), 36'(level), 36'd16);
            checkOutput($sformatf("stream%0d_data", i), out_data, q.pop_front());
            q.push_back(36'h0_0000_2000 + 36'(i));
            applyStimulus(1'b1, 36'h0_0000_2000 + 36'(i), 1'b0, 1'b1);
        end
        checkOutput("stream_drop_total", 36'(drop_total), 36'(exp_dt));
        drainQueue("drain_stream");

        // First free slot coincides with an incoming word
        fillWords(16, 36'h0_0000_3000);
        applyStimulus(1'b1, 36'h0_0000_3100, 1'b0, 1'b0);
        applyStimulus(1'b1, 36'h0_0000_3101, 1'b0, 1'b0);
        void'(q.pop_front());
        applyStimulus(1'b1, 36'h7_0000_00AA, 1'b0, 1'b1);
`ifdef ZVERIF_TRACE_MARKER_EN
        q.push_back(36'hF_0000_0003);
        exp_dt += 3;
`else
        q.push_back(36'h7_0000_00AA);
        exp_dt += 2;
`endif
        void'(q.pop_front());
        applyStimulus(1'b1, 36'h7_0000_00BB, 1'b0, 1'b1);
        q.push_back(36'h7_0000_00BB);
        checkOutput("coin_drop_total", 36'(drop_total), 36'(exp_dt));
        checkOutput("coin_level", 36'(level), 36'd16);
        drainQueue("drain_coin");

        // Flush with a partial fill, then flush while dropping
        fillWords(5, 36'h0_0000_4000);
        checkOutput("part_level", 36'(level), 36'd5);
        applyStimulus(1'b0, 36'd0, 1'b1, 1'b0);
        q.delete();
        checkOutput("flush1_level", 36'(level), 36'd0);
        checkOutput("flush1_valid", 36'(out_valid), 36'd0);
        fillWords(16, 36'h0_0000_5000);
        applyStimulus(1'b1, 36'h0_0000_5100, 1'b0, 1'b0);
        exp_dt += 1;
        applyStimulus(1'b1, 36'h9_9999_9999, 1'b1, 1'b0);
        q.delete();
        checkOutput("flush2_level", 36'(level), 36'd0);
        checkOutput("flush2_valid", 36'(out_valid), 36'd0);
        checkOutput("flush2_drop_total", 36'(drop_total), 36'(exp_dt));
        checkOutput("flush2_overflow", 36'(overflow), 36'd1);
        applyStimulus(1'b1, 36'h6_0000_0077, 1'b0, 1'b0);
        checkOutput("post_flush_valid", 36'(out_valid), 36'd1);
        checkOutput("post_flush_data", out_data, 36'h6_0000_0077);
        checkOutput("post_flush_level", 36'(level), 36'd1);

        // Reset in the middle of traffic
        applyStimulus(1'b1, 36'h6_0000_0078, 1'b0, 1'b0);
        resetn = 1'b0;
        applyStimulus(1'b1, 36'h6_0000_0079, 1'b0, 1'b1);
        checkOutput("mid_rst_valid", 36'(out_valid), 36'd0);
        checkOutput("mid_rst_data", out_data, 36'd0);
        checkOutput("mid_rst_level", 36'(level), 36'd0);
        checkOutput("mid_rst_overflow", 36'(overflow), 36'd0);
        checkOutput("mid_rst_drop_total", 36'(drop_total), 36'd0);
        resetn = 1'b1;
        applyStimulus(1'b0, 36'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
